// File: rtl/clb_cfg_loader_if.sv
// Bit-serial config stream in, CLB frame write port and status out.
// The loader sits on the slave modport; the stream source / array side uses master.
interface clb_cfg_loader_if #(
  parameter int ADDR_W  = 2,
  parameter int FRAME_W = 37
);
  logic               PROG;
  logic               DIN;
  logic               DIN_VALID;
  logic               DIN_READY;
  logic [ADDR_W-1:0]  CFG_ADDR;
  logic [FRAME_W-1:0] CFG_DATA;
  logic               CFG_WE;
  logic               HOLD;
  logic               DONE;
  logic               ERR;

  modport master (
    output PROG, DIN, DIN_VALID,
    input  DIN_READY, CFG_ADDR, CFG_DATA, CFG_WE, HOLD, DONE, ERR
  );

  modport slave (
    input  PROG, DIN, DIN_VALID,
    output DIN_READY, CFG_ADDR, CFG_DATA, CFG_WE, HOLD, DONE, ERR
  );
endinterface

// File: rtl/clb_cfg_loader.sv
// CLB configuration loader: hunts for 8'hB5, reads a frame count, then writes
// one parity-checked frame per CLB. The array is held until the whole load is good.
module clb_cfg_loader #(
  parameter int ADDR_W  = 2,
  parameter int FRAME_W = 37
) (
  input logic               K,
  input logic               RESET_N,
  clb_cfg_loader_if.slave   cfg
);
  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_COUNT, S_FRAME, S_PARITY, S_WRITE, S_DONE, S_ERROR
  } state_t;

  localparam int         CNT_W = $clog2(FRAME_W + 1);
  localparam logic [8:0] MAX_N = 9'(2 ** ADDR_W);

  state_t             state_q, state_d;
  logic [7:0]         win_q, win_d;
  logic [7:0]         n_q, n_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               par_q, par_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               ready_q, ready_d;
  logic               we_q, we_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               hold_q, hold_d;

  logic       accept;
  logic [7:0] win_nxt, n_nxt;
  logic       last_addr;

  assign accept    = cfg.DIN_VALID && ready_q;
  assign win_nxt   = {win_q[6:0], cfg.DIN};
  assign n_nxt     = {n_q[6:0], cfg.DIN};
  assign last_addr = (9'(addr_q) + 9'd1) == {1'b0, n_q};

  always_ff @(posedge K or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      frame_q <= '0;
      par_q   <= 1'b0;
      addr_q  <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      par_q   <= par_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  // PROG outranks everything, including a bit offered in the same cycle.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    par_d   = par_q;
    addr_d  = addr_q;
    if (cfg.PROG) begin
      state_d = S_SYNC;
      win_d   = '0;
      cnt_d   = '0;
      par_d   = 1'b0;
      addr_d  = '0;
    end else begin
      case (state_q)
        S_SYNC: if (accept) begin
          win_d = win_nxt;
          if (win_nxt == 8'hB5) begin
            state_d = S_COUNT;
            cnt_d   = '0;
          end
        end
        S_COUNT: if (accept) begin
          n_d   = n_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(7)) begin
            cnt_d = '0;
            if (n_nxt == 8'd0 || {1'b0, n_nxt} > MAX_N) begin
              state_d = S_ERROR;
            end else begin
              state_d = S_FRAME;
              addr_d  = '0;
              par_d   = 1'b0;
            end
          end
        end
        S_FRAME: if (accept) begin
          frame_d = {frame_q[FRAME_W-2:0], cfg.DIN};
          par_d   = par_q ^ cfg.DIN;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(FRAME_W - 1)) state_d = S_PARITY;
        end
        S_PARITY: if (accept) begin
          state_d = (par_q ^ cfg.DIN) ? S_ERROR : S_WRITE;
        end
        S_WRITE: begin
          if (last_addr) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FRAME;
            addr_d  = addr_q + 1'b1;
            cnt_d   = '0;
            par_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from the next state so every flag is registered yet
  // lines up with the state it describes.
  always_comb begin
    ready_d = 1'b0;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    hold_d  = 1'b1;
    case (state_d)
      S_SYNC, S_COUNT, S_FRAME, S_PARITY: ready_d = 1'b1;
      S_WRITE: we_d = 1'b1;
      S_DONE: begin
        done_d = 1'b1;
        hold_d = 1'b0;
      end
      S_ERROR: err_d = 1'b1;
      default: ;
    endcase
  end

  assign cfg.DIN_READY = ready_q;
  assign cfg.CFG_ADDR  = addr_q;
  assign cfg.CFG_DATA  = frame_q;
  assign cfg.CFG_WE    = we_q;
  assign cfg.HOLD      = hold_q;
  assign cfg.DONE      = done_q;
  assign cfg.ERR       = err_q;
endmodule

// File: tb/tb_clb_cfg_loader.sv
// Directed bench for clb_cfg_loader: table of whole-load scenarios plus
// restart and asynchronous-reset sequences.
module tb_clb_cfg_loader;
  localparam int ADDR_W  = 2;
  localparam int FRAME_W = 37;

  logic K = 1'b0;
  logic RESET_N = 1'b0;

  clb_cfg_loader_if #(.ADDR_W(ADDR_W), .FRAME_W(FRAME_W)) bus ();

  clb_cfg_loader #(.ADDR_W(ADDR_W), .FRAME_W(FRAME_W)) dut (
    .K       (K),
    .RESET_N (RESET_N),
    .cfg     (bus.slave)
  );

  always #5 K = ~K;

  int tests = 0;
  int fails = 0;

  logic [ADDR_W-1:0]  wa_q [$];
  logic [FRAME_W-1:0] wd_q [$];

  typedef struct {
    logic [7:0]              n;
    int                      nsend;
    int                      bad;
    bit                      garbage;
    bit                      gaps;
    bit                      exp_err;
    int                      exp_nwr;
    logic [3:0][FRAME_W-1:0] f;
  } vec_t;

  vec_t vec [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Write-port monitor: records every strobe and checks the stream is stalled.
  always @(negedge K) begin
    if (bus.CFG_WE === 1'b1) begin
      wa_q.push_back(bus.CFG_ADDR);
      wd_q.push_back(bus.CFG_DATA);
      chk("ready_low_in_write", 64'(bus.DIN_READY), 64'd0);
    end
  end

  task automatic send_bit(input logic b, input bit gaps);
    int g;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge K);
        bus.DIN_VALID = 1'b0;
        bus.DIN = 1'($urandom);
      end
    end
    @(negedge K);
    bus.DIN = b;
    bus.DIN_VALID = 1'b1;
    g = 0;
    while (bus.DIN_READY !== 1'b1 && g < 200) begin
      @(negedge K);
      g++;
    end
    if (g >= 200) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got DIN_READY=%b, expected 1", bus.DIN_READY);
    end
    @(posedge K);
  endtask

  task automatic send_field(input logic [63:0] v, input int w, input bit gaps);
    for (int i = w - 1; i >= 0; i--) send_bit(v[i], gaps);
  endtask

  task automatic send_frame(input logic [FRAME_W-1:0] f, input bit flip, input bit gaps);
    send_field(64'(f), FRAME_W, gaps);
    send_bit((^f) ^ flip, gaps);
  endtask

  task automatic prog();
    @(negedge K);
    bus.DIN_VALID = 1'b0;
    bus.PROG = 1'b1;
    @(negedge K);
    bus.PROG = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int nwr, input logic [3:0][FRAME_W-1:0] f);
    chk({tag, "_nwr"}, 64'(wa_q.size()), 64'(nwr));
    for (int i = 0; i < nwr && i < wa_q.size(); i++) begin
      chk({tag, "_addr"}, 64'(wa_q[i]), 64'(i));
      chk({tag, "_data"}, 64'(wd_q[i]), 64'(f[i]));
    end
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    string tag;
    v = vec[k];
    tag = $sformatf("vec%0d", k);
    wa_q.delete();
    wd_q.delete();
    prog();
    chk({tag, "_prog_ready"}, 64'(bus.DIN_READY), 64'd1);
    chk({tag, "_prog_flags"}, 64'({bus.HOLD, bus.DONE, bus.ERR}), 64'b100);
    if (v.garbage) send_field(64'b11100, 5, v.gaps);
    send_field(64'hB5, 8, v.gaps);
    send_field(64'(v.n), 8, v.gaps);
    for (int i = 0; i < v.nsend; i++) send_frame(v.f[i], i == v.bad, v.gaps);
    @(negedge K);
    bus.DIN_VALID = 1'b0;
    if (v.exp_err) begin
      chk({tag, "_err_flags"}, 64'({bus.ERR, bus.HOLD, bus.DONE, bus.CFG_WE}), 64'b1100);
    end else begin
      chk({tag, "_last_we"}, 64'({bus.CFG_WE, bus.DONE}), 64'b10);
      @(negedge K);
      chk({tag, "_done_flags"}, 64'({bus.DONE, bus.HOLD, bus.ERR, bus.CFG_WE}), 64'b1000);
    end
    repeat (3) @(negedge K);
    check_writes(tag, v.exp_nwr, v.f);
  endtask

  initial begin
    bus.PROG = 1'b0;
    bus.DIN = 1'b0;
    bus.DIN_VALID = 1'b0;

    vec[0] = '{8'd1, 1, -1, 1'b0, 1'b0, 1'b0, 1,
               {37'd0, 37'd0, 37'd0, 37'h15_0008_B038}};
    vec[1] = '{8'd4, 4, -1, 1'b1, 1'b1, 1'b0, 4,
               {37'h12_3456_789A, 37'h0A_5A5A_5A5A, 37'h00_0000_0001, 37'h1F_FFFF_FFFF}};
    vec[2] = '{8'd2, 2, 1, 1'b0, 1'b0, 1'b1, 1,
               {37'd0, 37'd0, 37'h05_DEAD_BEEF, 37'h1A_0F0F_1234}};
    vec[3] = '{8'd0, 0, -1, 1'b0, 1'b0, 1'b1, 0, '0};
    vec[4] = '{8'd5, 0, -1, 1'b0, 1'b0, 1'b1, 0, '0};
    vec[5] = '{8'd3, 3, -1, 1'b1, 1'b1, 1'b0, 3,
               {37'd0, 37'h03_8000_0001, 37'h1C_0000_0003, 37'h00_FFFF_0000}};

    // Reset values
    repeat (2) @(negedge K);
    chk("rst_flags", 64'({bus.HOLD, bus.DONE, bus.ERR, bus.CFG_WE, bus.DIN_READY}), 64'b10000);
    chk("rst_addr_data", 64'({bus.CFG_ADDR, bus.CFG_DATA}), 64'd0);
    RESET_N = 1'b1;
    repeat (2) @(negedge K);
    chk("idle_ready", 64'(bus.DIN_READY), 64'd0);

    for (int k = 0; k < 6; k++) run_vec(k);

    // Restart in the middle of frame 1 of an N=3 load
    begin
      logic [3:0][FRAME_W-1:0] fx;
      fx = {37'd0, 37'd0, 37'd0, 37'h0B_CAFE_0042};
      wa_q.delete();
      wd_q.delete();
      prog();
      send_field(64'hB5, 8, 1'b0);
      send_field(64'd3, 8, 1'b0);
      send_frame(37'h11_1111_1111, 1'b0, 1'b0);
      send_field(64'h3FF, 10, 1'b0);
      @(negedge K);
      bus.DIN_VALID = 1'b0;
      chk("rs_pre_nwr", 64'(wa_q.size()), 64'd1);
      wa_q.delete();
      wd_q.delete();
      prog();
      chk("rs_prog_flags", 64'({bus.HOLD, bus.DONE, bus.ERR, bus.CFG_ADDR}), 64'({1'b1, 1'b0, 1'b0, 2'd0}));
      send_field(64'hB5, 8, 1'b0);
      send_field(64'd1, 8, 1'b0);
      send_frame(fx[0], 1'b0, 1'b0);
      @(negedge K);
      chk("rs_we", 64'(bus.CFG_WE), 64'd1);
      @(negedge K);
      chk("rs_done", 64'({bus.DONE, bus.HOLD}), 64'b10);
      repeat (3) @(negedge K);
      check_writes("rs", 1, fx);
    end

    // Asynchronous reset during FRAME
    wa_q.delete();
    wd_q.delete();
    prog();
    send_field(64'hB5, 8, 1'b0);
    send_field(64'd2, 8, 1'b0);
    send_frame(37'h00_0000_00FF, 1'b0, 1'b0);
    send_field(64'hFFF, 12, 1'b0);
    @(negedge K);
    chk("ar_pre_addr", 64'(bus.CFG_ADDR), 64'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("ar_flags", 64'({bus.HOLD, bus.DONE, bus.ERR, bus.CFG_WE, bus.DIN_READY}), 64'b10000);
    chk("ar_addr_data", 64'({bus.CFG_ADDR, bus.CFG_DATA}), 64'd0);
    @(negedge K);
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge K);
      chk("ar_idle_ready", 64'(bus.DIN_READY), 64'd0);
    end
    prog();
    chk("ar_prog_ready", 64'(bus.DIN_READY), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
